// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: steps T-states, inserts memory wait
// states and drives every datapath strobe from the latched opcode.
module control_sequencer #(
  parameter int unsigned    OPW      = 5,
  parameter int unsigned    MEM_WAIT = 1,
  parameter logic [OPW-1:0] ALU_ADD  = OPW'(5'b00011)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           stop,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  output logic           PCout,
  output logic           ZLowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           Inport_out,
  output logic           Cout,
  output logic           BAout,
  output logic           MARin,
  output logic           MDRin,
  output logic           PCin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           CON_in,
  output logic           Outport_in,
  output logic           Rin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rout,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] alu_op,
  output logic           busy,
  output logic           halted
);

  // Strobe vector bit positions
  localparam int unsigned NSTRB        = 26;
  localparam int unsigned S_PCOUT      = 0;
  localparam int unsigned S_ZLOWOUT    = 1;
  localparam int unsigned S_ZHIGHOUT   = 2;
  localparam int unsigned S_MDROUT     = 3;
  localparam int unsigned S_HIOUT      = 4;
  localparam int unsigned S_LOOUT      = 5;
  localparam int unsigned S_INPORTOUT  = 6;
  localparam int unsigned S_COUT       = 7;
  localparam int unsigned S_MARIN      = 8;
  localparam int unsigned S_MDRIN      = 9;
  localparam int unsigned S_PCIN       = 10;
  localparam int unsigned S_IRIN       = 11;
  localparam int unsigned S_YIN        = 12;
  localparam int unsigned S_ZIN        = 13;
  localparam int unsigned S_HIIN       = 14;
  localparam int unsigned S_LOIN       = 15;
  localparam int unsigned S_CONIN      = 16;
  localparam int unsigned S_OUTPORTIN  = 17;
  localparam int unsigned S_RIN        = 18;
  localparam int unsigned S_GRA        = 19;
  localparam int unsigned S_GRB        = 20;
  localparam int unsigned S_GRC        = 21;
  localparam int unsigned S_ROUT       = 22;
  localparam int unsigned S_INCPC      = 23;
  localparam int unsigned S_READ       = 24;
  localparam int unsigned S_WRITE      = 25;

  // FSM states
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_T7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  // Opcodes
  localparam logic [OPW-1:0] OP_LD      = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI     = OPW'(1);
  localparam logic [OPW-1:0] OP_ST      = OPW'(2);
  localparam logic [OPW-1:0] OP_RALU_LO = OPW'(3);
  localparam logic [OPW-1:0] OP_RALU_HI = OPW'(12);
  localparam logic [OPW-1:0] OP_IALU_LO = OPW'(13);
  localparam logic [OPW-1:0] OP_IALU_HI = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL     = OPW'(16);
  localparam logic [OPW-1:0] OP_DIV     = OPW'(17);
  localparam logic [OPW-1:0] OP_BR      = OPW'(18);
  localparam logic [OPW-1:0] OP_JR      = OPW'(19);
  localparam logic [OPW-1:0] OP_JAL     = OPW'(20);
  localparam logic [OPW-1:0] OP_IN      = OPW'(21);
  localparam logic [OPW-1:0] OP_OUT     = OPW'(22);
  localparam logic [OPW-1:0] OP_MFHI    = OPW'(23);
  localparam logic [OPW-1:0] OP_MFLO    = OPW'(24);
  localparam logic [OPW-1:0] OP_HALT    = OPW'(26);

  localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

  logic [3:0]       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [2:0]       wait_q, wait_d;
  logic [NSTRB-1:0] strb_q, strb_d;
  logic [OPW-1:0]   alu_q, alu_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             br_t6_q, br_t6_d;

  logic [OPW-1:0]   ir_op;
  logic             mem_hold;
  logic             is_ld, is_ldi, is_st, is_mem;
  logic             is_ralu, is_ialu, is_alu, is_muldiv;
  logic             is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo;
  logic             unused_ir;

  assign ir_op     = ir[31:32-OPW];
  assign unused_ir = ^ir[31-OPW:0];
  // Current state is a Read/Write state whenever its registered strobe is up
  assign mem_hold  = strb_q[S_READ] | strb_q[S_WRITE];

  // Last execute state of each opcode; nop and undefined opcodes end at T2
  function automatic logic [3:0] final_state(input logic [OPW-1:0] op);
    logic [3:0] fs;
    fs = ST_T2;
    if (op == OP_LD || op == OP_ST) begin
      fs = ST_T7;
    end else if (op == OP_LDI || (op >= OP_RALU_LO && op <= OP_IALU_HI)) begin
      fs = ST_T5;
    end else if (op == OP_MUL || op == OP_DIV || op == OP_BR) begin
      fs = ST_T6;
    end else if (op == OP_JAL) begin
      fs = ST_T4;
    end else if (op == OP_JR || (op >= OP_IN && op <= OP_MFLO)) begin
      fs = ST_T3;
    end
    return fs;
  endfunction

  // State, opcode, wait counter and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      wait_q   <= 3'd0;
      strb_q   <= '0;
      alu_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      br_t6_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      strb_q   <= strb_d;
      alu_q    <= alu_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      br_t6_q  <= br_t6_d;
    end
  end

  // Next state, then strobes decoded from the next state and opcode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    strb_d    = '0;
    alu_d     = '0;
    br_t6_d   = 1'b0;
    busy_d    = 1'b0;
    halted_d  = 1'b0;
    is_ld     = 1'b0;
    is_ldi    = 1'b0;
    is_st     = 1'b0;
    is_mem    = 1'b0;
    is_ralu   = 1'b0;
    is_ialu   = 1'b0;
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    is_br     = 1'b0;
    is_jr     = 1'b0;
    is_jal    = 1'b0;
    is_in     = 1'b0;
    is_out    = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_T0;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (mem_hold && (wait_q != WAIT_MAX)) begin
          wait_d = wait_q + 3'd1;
        end else begin
          wait_d = 3'd0;
          if (state_q == ST_T2) begin
            // Opcode is taken straight from ir on the IRin edge
            op_d = ir_op;
            if (ir_op == OP_HALT) begin
              state_d = ST_HALT;
            end else if (final_state(ir_op) == ST_T2) begin
              state_d = stop ? ST_IDLE : ST_T0;
            end else begin
              state_d = ST_T3;
            end
          end else if (state_q == final_state(op_q)) begin
            state_d = stop ? ST_IDLE : ST_T0;
          end else begin
            state_d = state_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    is_ld     = (op_d == OP_LD);
    is_ldi    = (op_d == OP_LDI);
    is_st     = (op_d == OP_ST);
    is_mem    = is_ld | is_ldi | is_st;
    is_ralu   = (op_d >= OP_RALU_LO) && (op_d <= OP_RALU_HI);
    is_ialu   = (op_d >= OP_IALU_LO) && (op_d <= OP_IALU_HI);
    is_alu    = is_ralu | is_ialu;
    is_muldiv = (op_d == OP_MUL) || (op_d == OP_DIV);
    is_br     = (op_d == OP_BR);
    is_jr     = (op_d == OP_JR);
    is_jal    = (op_d == OP_JAL);
    is_in     = (op_d == OP_IN);
    is_out    = (op_d == OP_OUT);
    is_mfhi   = (op_d == OP_MFHI);
    is_mflo   = (op_d == OP_MFLO);

    busy_d   = (state_d >= ST_T0) && (state_d <= ST_T7);
    halted_d = (state_d == ST_HALT);

    case (state_d)
      ST_T0: begin
        strb_d[S_PCOUT] = 1'b1;
        strb_d[S_MARIN] = 1'b1;
        strb_d[S_INCPC] = 1'b1;
        strb_d[S_ZIN]   = 1'b1;
      end
      ST_T1: begin
        strb_d[S_ZLOWOUT] = 1'b1;
        strb_d[S_PCIN]    = 1'b1;
        strb_d[S_READ]    = 1'b1;
        strb_d[S_MDRIN]   = 1'b1;
      end
      ST_T2: begin
        strb_d[S_MDROUT] = 1'b1;
        strb_d[S_IRIN]   = 1'b1;
      end
      ST_T3: begin
        if (is_mem || is_alu) begin
          strb_d[S_GRB]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_YIN]  = 1'b1;
        end else if (is_muldiv) begin
          strb_d[S_GRA]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_YIN]  = 1'b1;
        end else if (is_br) begin
          strb_d[S_GRA]   = 1'b1;
          strb_d[S_ROUT]  = 1'b1;
          strb_d[S_CONIN] = 1'b1;
        end else if (is_jr) begin
          strb_d[S_GRA]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_PCIN] = 1'b1;
        end else if (is_jal) begin
          strb_d[S_PCOUT] = 1'b1;
          strb_d[S_GRB]   = 1'b1;
          strb_d[S_RIN]   = 1'b1;
        end else if (is_in) begin
          strb_d[S_INPORTOUT] = 1'b1;
          strb_d[S_GRA]       = 1'b1;
          strb_d[S_RIN]       = 1'b1;
        end else if (is_out) begin
          strb_d[S_GRA]        = 1'b1;
          strb_d[S_ROUT]       = 1'b1;
          strb_d[S_OUTPORTIN]  = 1'b1;
        end else if (is_mfhi) begin
          strb_d[S_HIOUT] = 1'b1;
          strb_d[S_GRA]   = 1'b1;
          strb_d[S_RIN]   = 1'b1;
        end else if (is_mflo) begin
          strb_d[S_LOOUT] = 1'b1;
          strb_d[S_GRA]   = 1'b1;
          strb_d[S_RIN]   = 1'b1;
        end
      end
      ST_T4: begin
        if (is_mem) begin
          strb_d[S_COUT] = 1'b1;
          strb_d[S_ZIN]  = 1'b1;
          alu_d          = ALU_ADD;
        end else if (is_ralu) begin
          strb_d[S_GRC]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_ZIN]  = 1'b1;
          alu_d          = op_d;
        end else if (is_ialu) begin
          strb_d[S_COUT] = 1'b1;
          strb_d[S_ZIN]  = 1'b1;
          alu_d          = op_d;
        end else if (is_muldiv) begin
          strb_d[S_GRB]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_ZIN]  = 1'b1;
          alu_d          = op_d;
        end else if (is_br) begin
          strb_d[S_PCOUT] = 1'b1;
          strb_d[S_YIN]   = 1'b1;
        end else if (is_jal) begin
          strb_d[S_GRA]  = 1'b1;
          strb_d[S_ROUT] = 1'b1;
          strb_d[S_PCIN] = 1'b1;
        end
      end
      ST_T5: begin
        if (is_ldi || is_alu) begin
          strb_d[S_ZLOWOUT] = 1'b1;
          strb_d[S_GRA]     = 1'b1;
          strb_d[S_RIN]     = 1'b1;
        end else if (is_ld || is_st) begin
          strb_d[S_ZLOWOUT] = 1'b1;
          strb_d[S_MARIN]   = 1'b1;
        end else if (is_muldiv) begin
          strb_d[S_ZLOWOUT] = 1'b1;
          strb_d[S_LOIN]    = 1'b1;
        end else if (is_br) begin
          strb_d[S_COUT] = 1'b1;
          strb_d[S_ZIN]  = 1'b1;
          alu_d          = ALU_ADD;
        end
      end
      ST_T6: begin
        if (is_ld) begin
          strb_d[S_READ]  = 1'b1;
          strb_d[S_MDRIN] = 1'b1;
        end else if (is_st) begin
          strb_d[S_GRA]   = 1'b1;
          strb_d[S_ROUT]  = 1'b1;
          strb_d[S_MDRIN] = 1'b1;
        end else if (is_muldiv) begin
          strb_d[S_ZHIGHOUT] = 1'b1;
          strb_d[S_HIIN]     = 1'b1;
        end else if (is_br) begin
          strb_d[S_ZLOWOUT] = 1'b1;
          br_t6_d           = 1'b1;
        end
      end
      ST_T7: begin
        if (is_ld) begin
          strb_d[S_MDROUT] = 1'b1;
          strb_d[S_GRA]    = 1'b1;
          strb_d[S_RIN]    = 1'b1;
        end else if (is_st) begin
          strb_d[S_WRITE] = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Strobe outputs straight from their registers
  assign PCout      = strb_q[S_PCOUT];
  assign ZLowout    = strb_q[S_ZLOWOUT];
  assign ZHighout   = strb_q[S_ZHIGHOUT];
  assign MDRout     = strb_q[S_MDROUT];
  assign HIout      = strb_q[S_HIOUT];
  assign LOout      = strb_q[S_LOOUT];
  assign Inport_out = strb_q[S_INPORTOUT];
  assign Cout       = strb_q[S_COUT];
  assign BAout      = 1'b0;
  assign MARin      = strb_q[S_MARIN];
  assign MDRin      = strb_q[S_MDRIN];
  // Branch T6 loads PC only while con_ff is high, sampled within the cycle
  assign PCin       = strb_q[S_PCIN] | (br_t6_q & con_ff);
  assign IRin       = strb_q[S_IRIN];
  assign Yin        = strb_q[S_YIN];
  assign Zin        = strb_q[S_ZIN];
  assign HIin       = strb_q[S_HIIN];
  assign LOin       = strb_q[S_LOIN];
  assign CON_in     = strb_q[S_CONIN];
  assign Outport_in = strb_q[S_OUTPORTIN];
  assign Rin        = strb_q[S_RIN];
  assign Gra        = strb_q[S_GRA];
  assign Grb        = strb_q[S_GRB];
  assign Grc        = strb_q[S_GRC];
  assign Rout       = strb_q[S_ROUT];
  assign IncPC      = strb_q[S_INCPC];
  assign Read       = strb_q[S_READ];
  assign Write      = strb_q[S_WRITE];
  assign alu_op     = alu_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle strobe words are
// queued by the stimulus and popped by a monitor on every busy cycle.
module tb_control_sequencer;

  localparam int unsigned OPW = 5;
  localparam int unsigned MW  = 1;

  // Observed word bit masks
  localparam logic [28:0] B_PCOUT     = 29'h1 << 0;
  localparam logic [28:0] B_ZLOWOUT   = 29'h1 << 1;
  localparam logic [28:0] B_ZHIGHOUT  = 29'h1 << 2;
  localparam logic [28:0] B_MDROUT    = 29'h1 << 3;
  localparam logic [28:0] B_HIOUT     = 29'h1 << 4;
  localparam logic [28:0] B_LOOUT     = 29'h1 << 5;
  localparam logic [28:0] B_INPORT    = 29'h1 << 6;
  localparam logic [28:0] B_COUT      = 29'h1 << 7;
  localparam logic [28:0] B_MARIN     = 29'h1 << 9;
  localparam logic [28:0] B_MDRIN     = 29'h1 << 10;
  localparam logic [28:0] B_PCIN      = 29'h1 << 11;
  localparam logic [28:0] B_IRIN      = 29'h1 << 12;
  localparam logic [28:0] B_YIN       = 29'h1 << 13;
  localparam logic [28:0] B_ZIN       = 29'h1 << 14;
  localparam logic [28:0] B_HIIN      = 29'h1 << 15;
  localparam logic [28:0] B_LOIN      = 29'h1 << 16;
  localparam logic [28:0] B_CONIN     = 29'h1 << 17;
  localparam logic [28:0] B_OUTPORT   = 29'h1 << 18;
  localparam logic [28:0] B_RIN       = 29'h1 << 19;
  localparam logic [28:0] B_GRA       = 29'h1 << 20;
  localparam logic [28:0] B_GRB       = 29'h1 << 21;
  localparam logic [28:0] B_GRC       = 29'h1 << 22;
  localparam logic [28:0] B_ROUT      = 29'h1 << 23;
  localparam logic [28:0] B_INCPC     = 29'h1 << 24;
  localparam logic [28:0] B_READ      = 29'h1 << 25;
  localparam logic [28:0] B_WRITE     = 29'h1 << 26;
  localparam logic [28:0] B_BUSY      = 29'h1 << 27;
  localparam logic [28:0] B_HALTED    = 29'h1 << 28;

  logic clk = 1'b0;
  logic rst, run, stop, con_ff;
  logic [31:0] ir;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Inport_out, Cout, BAout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, CON_in, Outport_in, Rin;
  logic Gra, Grb, Grc, Rout, IncPC, Read, Write, busy, halted;
  logic [OPW-1:0] alu_op;
  logic [28:0] obs;

  typedef struct {
    logic [28:0] sig;
    logic [4:0]  alu;
    bit          alu_chk;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc;

  control_sequencer #(.OPW(OPW), .MEM_WAIT(MW), .ALU_ADD(5'b00011)) dut (
    .clk(clk), .rst(rst), .run(run), .stop(stop), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Inport_out(Inport_out), .Cout(Cout),
    .BAout(BAout), .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .CON_in(CON_in),
    .Outport_in(Outport_in), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op),
    .busy(busy), .halted(halted)
  );

  assign obs = {halted, busy, Write, Read, IncPC, Rout, Grc, Grb, Gra, Rin,
                Outport_in, CON_in, LOin, HIin, Zin, Yin, IRin, PCin, MDRin,
                MARin, BAout, Cout, Inport_out, LOout, HIout, MDRout, ZHighout,
                ZLowout, PCout};

  always #5 clk = ~clk;

  // Monitor: one expected word per busy cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busy: got sig=%h, required no busy cycle", obs);
      end else begin
        e = sb_q.pop_front();
        if (obs !== e.sig || (e.alu_chk && alu_op !== e.alu)) begin
          errors++;
          $display("FAIL %s: got sig=%h alu=%b, required sig=%h alu=%b",
                   e.name, obs, alu_op, e.sig, e.alu);
        end
      end
    end
  end

  task automatic push(input logic [28:0] s, input logic [4:0] a, input bit ac,
                      input string n);
    exp_t e;
    e.sig = s | B_BUSY;
    e.alu = a;
    e.alu_chk = ac;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch(input string tag);
    push(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 1'b0, {tag, "_T0"});
    for (int i = 0; i <= int'(MW); i++)
      push(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 5'd0, 1'b0, {tag, "_T1"});
    push(B_MDROUT | B_IRIN, 5'd0, 1'b0, {tag, "_T2"});
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, got, req);
    end
  endtask

  task automatic start(input logic [31:0] i, input logic s, input logic c);
    @(negedge clk);
    ir = i;
    stop = s;
    con_ff = c;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Cycles from T0 until busy drops, bounded
  task automatic wait_idle(input int maxc, output int n);
    n = 1;
    while (busy === 1'b1 && n < maxc) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) n++;
      else break;
    end
    if (busy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
    #2 rst = 1'b0;
    #10;
    chk("reset_outputs", 32'(obs), 32'h0);
    chk("reset_alu_op", 32'(alu_op), 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_run0", 32'(obs), 32'h0);

    // add twice back-to-back, stop raised during the second T4
    for (int k = 0; k < 2; k++) begin
      push_fetch("add");
      push(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, "add_T3");
      push(B_GRC | B_ROUT | B_ZIN, 5'b00011, 1'b1, "add_T4");
      push(B_ZLOWOUT | B_GRA | B_RIN, 5'd0, 1'b0, "add_T5");
    end
    start(32'h1800_0000, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    stop = 1'b1;
    wait_idle(20, cyc);
    chk("add_stop_cycles", 32'(cyc), 32'd2);
    chk("add_stop_idle", 32'(obs), 32'h0);
    chk("add_sb_empty", 32'(sb_q.size()), 32'd0);

    // ld with one wait state
    push_fetch("ld");
    push(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, "ld_T3");
    push(B_COUT | B_ZIN, 5'b00011, 1'b1, "ld_T4");
    push(B_ZLOWOUT | B_MARIN, 5'd0, 1'b0, "ld_T5");
    push(B_READ | B_MDRIN, 5'd0, 1'b0, "ld_T6a");
    push(B_READ | B_MDRIN, 5'd0, 1'b0, "ld_T6b");
    push(B_MDROUT | B_GRA | B_RIN, 5'd0, 1'b0, "ld_T7");
    start(32'h0300_0002, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("ld_cycles", 32'(cyc), 32'd10);
    chk("ld_sb_empty", 32'(sb_q.size()), 32'd0);

    // st
    push_fetch("st");
    push(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, "st_T3");
    push(B_COUT | B_ZIN, 5'b00011, 1'b1, "st_T4");
    push(B_ZLOWOUT | B_MARIN, 5'd0, 1'b0, "st_T5");
    push(B_GRA | B_ROUT | B_MDRIN, 5'd0, 1'b0, "st_T6");
    push(B_WRITE, 5'd0, 1'b0, "st_T7a");
    push(B_WRITE, 5'd0, 1'b0, "st_T7b");
    start(32'h1000_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("st_cycles", 32'(cyc), 32'd10);

    // br not taken, then taken
    for (int k = 0; k < 2; k++) begin
      push_fetch("br");
      push(B_GRA | B_ROUT | B_CONIN, 5'd0, 1'b0, "br_T3");
      push(B_PCOUT | B_YIN, 5'd0, 1'b0, "br_T4");
      push(B_COUT | B_ZIN, 5'b00011, 1'b1, "br_T5");
      push(B_ZLOWOUT | ((k == 1) ? B_PCIN : 29'h0), 5'd0, 1'b0,
           (k == 1) ? "br_T6_taken" : "br_T6_not_taken");
      start(32'h9000_0019, 1'b1, (k == 1));
      wait_idle(40, cyc);
      chk("br_cycles", 32'(cyc), 32'd8);
    end

    // mul
    push_fetch("mul");
    push(B_GRA | B_ROUT | B_YIN, 5'd0, 1'b0, "mul_T3");
    push(B_GRB | B_ROUT | B_ZIN, 5'b10000, 1'b1, "mul_T4");
    push(B_ZLOWOUT | B_LOIN, 5'd0, 1'b0, "mul_T5");
    push(B_ZHIGHOUT | B_HIIN, 5'd0, 1'b0, "mul_T6");
    start(32'h8000_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("mul_cycles", 32'(cyc), 32'd8);

    // immediate ALU (opcode 01101)
    push_fetch("addi");
    push(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, "addi_T3");
    push(B_COUT | B_ZIN, 5'b01101, 1'b1, "addi_T4");
    push(B_ZLOWOUT | B_GRA | B_RIN, 5'd0, 1'b0, "addi_T5");
    start(32'h6800_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("addi_cycles", 32'(cyc), 32'd7);

    // jal
    push_fetch("jal");
    push(B_PCOUT | B_GRB | B_RIN, 5'd0, 1'b0, "jal_T3");
    push(B_GRA | B_ROUT | B_PCIN, 5'd0, 1'b0, "jal_T4");
    start(32'hA000_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("jal_cycles", 32'(cyc), 32'd6);

    // mfhi
    push_fetch("mfhi");
    push(B_HIOUT | B_GRA | B_RIN, 5'd0, 1'b0, "mfhi_T3");
    start(32'hB800_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("mfhi_cycles", 32'(cyc), 32'd5);

    // nop and an undefined opcode end after fetch
    push_fetch("nop");
    start(32'hC800_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("nop_cycles", 32'(cyc), 32'd4);
    push_fetch("undef");
    start(32'hF800_0000, 1'b1, 1'b0);
    wait_idle(40, cyc);
    chk("undef_cycles", 32'(cyc), 32'd4);
    chk("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    // halt: sticky until reset
    push_fetch("halt");
    start(32'hD000_0000, 1'b0, 1'b0);
    wait_idle(40, cyc);
    chk("halt_fetch_cycles", 32'(cyc), 32'd4);
    chk("halt_state", 32'(obs), 32'(B_HALTED));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = ~run;
      stop = ~stop;
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_ignores_run", 32'(obs), 32'(B_HALTED));
    #2 rst = 1'b0;
    #1 chk("halt_reset", 32'(obs), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_halt_idle", 32'(obs), 32'h0);

    // async reset during ld T6 drops Read/MDRin without a clock edge
    push_fetch("ldr");
    push(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b0, "ldr_T3");
    push(B_COUT | B_ZIN, 5'b00011, 1'b1, "ldr_T4");
    push(B_ZLOWOUT | B_MARIN, 5'd0, 1'b0, "ldr_T5");
    push(B_READ | B_MDRIN, 5'd0, 1'b0, "ldr_T6");
    start(32'h0300_0002, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_read_mdrin", {30'd0, Read, MDRin}, 32'h0);
    chk("rst_all_zero", 32'(obs), 32'h0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    @(negedge clk) rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
